// File: rtl/gfg_video_pkg.sv
// Shared video timing definitions: vertical FSM encoding and default 640x480 timing.
package gfg_video_pkg;

    // Vertical region of the frame; each state starts on a line boundary.
    typedef enum logic [1:0] {
        VVis  = 2'd0,
        VFp   = 2'd1,
        VSync = 2'd2,
        VBp   = 2'd3
    } v_state_e;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FRONT  = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BACK   = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FRONT  = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BACK   = 33;
    localparam int unsigned DEF_PIXEL_W  = 12;
    localparam int unsigned DEF_ADDR_W   = 19;

endpackage

// File: rtl/display_scanout_controller_if.sv
// Frame buffer read port: address out, data back one cycle later, plus buffer select.
interface display_scanout_controller_if #(
    parameter int unsigned ADDR_W  = 19,
    parameter int unsigned PIXEL_W = 12
);
    logic [ADDR_W-1:0]  rd_addr;
    logic [PIXEL_W-1:0] rd_data;
    logic               read_buffer_sel;

    modport master (output rd_addr, output read_buffer_sel, input rd_data);
    modport slave  (input rd_addr, input read_buffer_sel, output rd_data);
endinterface

// File: rtl/video_timing_counter.sv
// Horizontal/vertical raster counters, vertical region FSM and region decode.
module video_timing_counter
    import gfg_video_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FRONT  = DEF_H_FRONT,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BACK   = DEF_H_BACK,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FRONT  = DEF_V_FRONT,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BACK   = DEF_V_BACK
) (
    input  logic i_clk,
    input  logic i_arst,
    output logic o_visible,
    output logic o_hsync_n,
    output logic o_vsync_n,
    output logic o_frame_end,
    output logic o_swap_window_next
);
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HCNT_W   = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int unsigned VCNT_W   = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
    localparam int unsigned HS_START = H_ACTIVE + H_FRONT;
    localparam int unsigned HS_END   = HS_START + H_SYNC;

    logic [HCNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [VCNT_W-1:0] v_cnt_q, v_cnt_d;
    v_state_e          v_state_q, v_state_d;
    int unsigned       h_pos, v_pos, v_pos_next;
    logic              h_last, v_last;

    assign h_pos      = 32'(h_cnt_q);
    assign v_pos      = 32'(v_cnt_q);
    assign v_pos_next = 32'(v_cnt_d);
    assign h_last     = (h_pos == H_TOTAL - 1);
    assign v_last     = (v_pos == V_TOTAL - 1);

    // Next raster position; the vertical side only moves when a line wraps.
    always_comb begin
        h_cnt_d   = h_last ? '0 : h_cnt_q + HCNT_W'(1);
        v_cnt_d   = v_cnt_q;
        v_state_d = v_state_q;
        if (h_last) begin
            v_cnt_d = v_last ? '0 : v_cnt_q + VCNT_W'(1);
            case (v_state_q)
                VVis:    if (v_pos == V_ACTIVE - 1) v_state_d = VFp;
                VFp:     if (v_pos == V_ACTIVE + V_FRONT - 1) v_state_d = VSync;
                VSync:   if (v_pos == V_ACTIVE + V_FRONT + V_SYNC - 1) v_state_d = VBp;
                VBp:     if (v_last) v_state_d = VVis;
                default: v_state_d = VVis;
            endcase
        end
    end

    // Counter and vertical FSM state registers.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            v_state_q <= VVis;
        end else begin
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            v_state_q <= v_state_d;
        end
    end

    assign o_visible   = (h_pos < H_ACTIVE) && (v_state_q == VVis);
    assign o_hsync_n   = !((h_pos >= HS_START) && (h_pos < HS_END));
    assign o_vsync_n   = (v_state_q != VSync);
    assign o_frame_end = h_last && v_last;
    // Decoded from the next line so the registered flag lines up with v_cnt.
    assign o_swap_window_next = (v_pos_next >= V_ACTIVE) && (v_pos_next <= V_TOTAL - 2);

endmodule

// File: rtl/display_scanout_controller.sv
// Scans a double-buffered frame out to a video port with a two-stage output pipeline.
module display_scanout_controller
    import gfg_video_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FRONT  = DEF_H_FRONT,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BACK   = DEF_H_BACK,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FRONT  = DEF_V_FRONT,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BACK   = DEF_V_BACK,
    parameter int unsigned PIXEL_W  = DEF_PIXEL_W,
    parameter int unsigned ADDR_W   = DEF_ADDR_W
) (
    input  logic                         i_clk,
    input  logic                         i_arst,
    input  logic                         i_rasterization_target,
    output logic                         o_frame_buffer_swap_allowed,
    display_scanout_controller_if.master fb,
    output logic                         o_hsync,
    output logic                         o_vsync,
    output logic                         o_de,
    output logic [PIXEL_W-1:0]           o_pixel
);
    logic visible, hsync_n, vsync_n, frame_end, swap_window_next;

    video_timing_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FRONT  (H_FRONT),
        .H_SYNC   (H_SYNC),
        .H_BACK   (H_BACK),
        .V_ACTIVE (V_ACTIVE),
        .V_FRONT  (V_FRONT),
        .V_SYNC   (V_SYNC),
        .V_BACK   (V_BACK)
    ) u_timing (
        .i_clk              (i_clk),
        .i_arst             (i_arst),
        .o_visible          (visible),
        .o_hsync_n          (hsync_n),
        .o_vsync_n          (vsync_n),
        .o_frame_end        (frame_end),
        .o_swap_window_next (swap_window_next)
    );

    logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
    logic               read_sel_q, read_sel_d;
    logic               swap_q, swap_d;
    logic               de_s1_q, de_s1_d, hsync_s1_q, hsync_s1_d, vsync_s1_q, vsync_s1_d;
    logic               de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d;
    logic [PIXEL_W-1:0] pixel_q, pixel_d;

    // Address counts visible pixels; buffer select only changes at the very end of a frame.
    always_comb begin
        rd_addr_d = rd_addr_q;
        if (frame_end) begin
            rd_addr_d = '0;
        end else if (visible) begin
            rd_addr_d = rd_addr_q + ADDR_W'(1);
        end
        read_sel_d = frame_end ? ~i_rasterization_target : read_sel_q;
        swap_d     = swap_window_next;
    end

    // Stage 1 waits for the RAM read; stage 2 pairs the controls with the returned pixel.
    always_comb begin
        de_s1_d    = visible;
        hsync_s1_d = hsync_n;
        vsync_s1_d = vsync_n;
        de_d       = de_s1_q;
        hsync_d    = hsync_s1_q;
        vsync_d    = vsync_s1_q;
        pixel_d    = de_s1_q ? fb.rd_data : '0;
    end

    // All scanout state, cleared asynchronously so outputs go idle without a clock.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            rd_addr_q  <= '0;
            read_sel_q <= 1'b1;
            swap_q     <= 1'b0;
            de_s1_q    <= 1'b0;
            hsync_s1_q <= 1'b1;
            vsync_s1_q <= 1'b1;
            de_q       <= 1'b0;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            pixel_q    <= '0;
        end else begin
            rd_addr_q  <= rd_addr_d;
            read_sel_q <= read_sel_d;
            swap_q     <= swap_d;
            de_s1_q    <= de_s1_d;
            hsync_s1_q <= hsync_s1_d;
            vsync_s1_q <= vsync_s1_d;
            de_q       <= de_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            pixel_q    <= pixel_d;
        end
    end

    assign fb.rd_addr                  = rd_addr_q;
    assign fb.read_buffer_sel          = read_sel_q;
    assign o_frame_buffer_swap_allowed = swap_q;
    assign o_hsync                     = hsync_q;
    assign o_vsync                     = vsync_q;
    assign o_de                        = de_q;
    assign o_pixel                     = pixel_q;

endmodule

// File: tb/tb_display_scanout_controller.sv
// Bench for display_scanout_controller on a small 8x6 raster with a data=address RAM.
module tb_display_scanout_controller;
    localparam int unsigned HA = 4, HF = 1, HS = 2, HB = 1;
    localparam int unsigned VA = 3, VF = 1, VS = 1, VB = 1;
    localparam int unsigned PIXEL_W = 12, ADDR_W = 19;
    localparam int unsigned HT = HA + HF + HS + HB;
    localparam int unsigned VT = VA + VF + VS + VB;
    localparam int unsigned FT = HT * VT;

    logic clk = 1'b0;
    logic arst = 1'b1;
    logic target = 1'b0;
    logic swap, hsync, vsync, de;
    logic [PIXEL_W-1:0] pixel;

    display_scanout_controller_if #(.ADDR_W(ADDR_W), .PIXEL_W(PIXEL_W)) fb_if ();

    display_scanout_controller #(
        .H_ACTIVE (HA), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
        .V_ACTIVE (VA), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
        .PIXEL_W  (PIXEL_W), .ADDR_W (ADDR_W)
    ) dut (
        .i_clk                       (clk),
        .i_arst                      (arst),
        .i_rasterization_target      (target),
        .o_frame_buffer_swap_allowed (swap),
        .fb                          (fb_if),
        .o_hsync                     (hsync),
        .o_vsync                     (vsync),
        .o_de                        (de),
        .o_pixel                     (pixel)
    );

    always #5 clk = ~clk;

    // Frame buffer: one-cycle read latency, contents equal to the address.
    always_ff @(posedge clk) fb_if.rd_data <= PIXEL_W'(fb_if.rd_addr);

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    int unsigned n_edge = 0;
    logic sel_m = 1'b1;

    typedef struct {
        logic de, hs, vs, swap, sel;
        logic [PIXEL_W-1:0] pix;
        logic [ADDR_W-1:0]  addr;
    } exp_t;

    typedef struct {
        int unsigned n;
        logic de, hs, vs, swap;
        logic [PIXEL_W-1:0] pix;
        logic [ADDR_W-1:0]  addr;
    } vec_t;

    vec_t tbl[20];

    function automatic vec_t mk(int unsigned n, logic d, logic h, logic v, logic s,
                                int unsigned p, int unsigned a);
        vec_t r;
        r.n = n; r.de = d; r.hs = h; r.vs = v; r.swap = s;
        r.pix = PIXEL_W'(p); r.addr = ADDR_W'(a);
        return r;
    endfunction

    function automatic exp_t reset_exp();
        exp_t e;
        e.de = 1'b0; e.hs = 1'b1; e.vs = 1'b1; e.swap = 1'b0; e.sel = 1'b1;
        e.pix = '0; e.addr = '0;
        return e;
    endfunction

    // Expected outputs n clock edges after reset release, from the raster rules.
    function automatic exp_t model(int unsigned n, logic sel);
        exp_t e;
        int unsigned p, v, m, hm, vm, cnt;
        p = n % FT;
        v = p / HT;
        cnt = 0;
        for (int unsigned q = 0; q < p; q++)
            if ((q % HT) < HA && (q / HT) < VA) cnt++;
        e.addr = ADDR_W'(cnt);
        e.swap = (v >= VA) && (v <= VT - 2);
        e.sel  = sel;
        if (n < 2) begin
            e.de = 1'b0; e.hs = 1'b1; e.vs = 1'b1; e.pix = '0;
        end else begin
            m  = (n - 2) % FT;
            hm = m % HT;
            vm = m / HT;
            e.de  = (hm < HA) && (vm < VA);
            e.hs  = !((hm >= HA + HF) && (hm < HA + HF + HS));
            e.vs  = !((vm >= VA + VF) && (vm < VA + VF + VS));
            e.pix = e.de ? PIXEL_W'(vm * HA + hm) : '0;
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input exp_t e);
        string t;
        t = $sformatf("%s@%0d", tag, n_edge);
        check({t, ".de"},    32'(de),                    32'(e.de));
        check({t, ".hsync"}, 32'(hsync),                 32'(e.hs));
        check({t, ".vsync"}, 32'(vsync),                 32'(e.vs));
        check({t, ".swap"},  32'(swap),                  32'(e.swap));
        check({t, ".sel"},   32'(fb_if.read_buffer_sel), 32'(e.sel));
        check({t, ".pixel"}, 32'(pixel),                 32'(e.pix));
        check({t, ".addr"},  32'(fb_if.rd_addr),         32'(e.addr));
    endtask

    // One clock: the model's buffer select loads at the edge that ends the last frame cycle.
    task automatic step();
        @(posedge clk);
        if ((n_edge % FT) == FT - 1) sel_m = ~target;
        n_edge++;
        @(negedge clk);
    endtask

    task automatic run_until(input string tag, input int unsigned p);
        do begin
            step();
            check_all(tag, model(n_edge, sel_m));
        end while ((n_edge % FT) != p);
    endtask

    initial begin
        // n, de, hsync, vsync, swap, pixel, addr
        tbl[0]  = mk(0,  0, 1, 1, 0, 0,  0);
        tbl[1]  = mk(1,  0, 1, 1, 0, 0,  1);
        tbl[2]  = mk(2,  1, 1, 1, 0, 0,  2);
        tbl[3]  = mk(3,  1, 1, 1, 0, 1,  3);
        tbl[4]  = mk(5,  1, 1, 1, 0, 3,  4);
        tbl[5]  = mk(6,  0, 1, 1, 0, 0,  4);
        tbl[6]  = mk(7,  0, 0, 1, 0, 0,  4);
        tbl[7]  = mk(8,  0, 0, 1, 0, 0,  4);
        tbl[8]  = mk(9,  0, 1, 1, 0, 0,  5);
        tbl[9]  = mk(10, 1, 1, 1, 0, 4,  6);
        tbl[10] = mk(21, 1, 1, 1, 0, 11, 12);
        tbl[11] = mk(26, 0, 1, 1, 1, 0,  12);
        tbl[12] = mk(34, 0, 1, 0, 1, 0,  12);
        tbl[13] = mk(39, 0, 0, 0, 1, 0,  12);
        tbl[14] = mk(40, 0, 0, 0, 0, 0,  12);
        tbl[15] = mk(42, 0, 1, 1, 0, 0,  12);
        tbl[16] = mk(47, 0, 0, 1, 0, 0,  12);
        tbl[17] = mk(48, 0, 0, 1, 0, 0,  0);
        tbl[18] = mk(50, 1, 1, 1, 0, 0,  2);
        tbl[19] = mk(51, 1, 1, 1, 0, 1,  3);

        repeat (3) @(negedge clk);
        check_all("reset", reset_exp());
        arst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            while (n_edge < tbl[i].n) step();
            check($sformatf("tbl%0d.de", i),    32'(de),            32'(tbl[i].de));
            check($sformatf("tbl%0d.hsync", i), 32'(hsync),         32'(tbl[i].hs));
            check($sformatf("tbl%0d.vsync", i), 32'(vsync),         32'(tbl[i].vs));
            check($sformatf("tbl%0d.swap", i),  32'(swap),          32'(tbl[i].swap));
            check($sformatf("tbl%0d.pixel", i), 32'(pixel),         32'(tbl[i].pix));
            check($sformatf("tbl%0d.addr", i),  32'(fb_if.rd_addr), 32'(tbl[i].addr));
        end

        // Asynchronous reset pulse between edges on line 2, then restart from (0,0).
        run_until("pre_reset", 2 * HT + 2);
        #2 arst = 1'b1;
        #1 check_all("arst_pulse", reset_exp());
        #1 arst = 1'b0;
        n_edge = 0;
        sel_m  = 1'b1;
        check_all("arst_release", model(0, 1'b1));

        // Target change mid-frame must not affect the buffer until the frame ends.
        run_until("mid_frame", HT);
        target = 1'b1;
        run_until("hold", FT - 1);
        check("sel_hold_last_cycle", 32'(fb_if.read_buffer_sel), 32'd1);
        step();
        check_all("frame_swap", model(n_edge, sel_m));
        check("sel_after_frame", 32'(fb_if.read_buffer_sel), 32'd0);

        // Target changes in the load cycle itself: the new value is the one sampled.
        run_until("to_load", FT - 1);
        target = 1'b0;
        step();
        check("sel_load_cycle", 32'(fb_if.read_buffer_sel), 32'd1);
        check_all("load_cycle", model(n_edge, sel_m));

        // Random target activity over several frames.
        for (int i = 0; i < 4 * FT; i++) begin
            if ($urandom_range(0, 7) == 0) target = ~target;
            step();
            check_all("rand", model(n_edge, sel_m));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
